// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO enqueue arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'h0,
        GRANT = 2'h1,
        FLUSH = 2'h2
    } arb_state_t;

    // Single-step modulo: callers only ever pass i < 2*n.
    function automatic int unsigned idx_wrap(input int unsigned i, input int unsigned n);
        return (i >= n) ? (i - n) : i;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first valid index at or after start_i, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int num_req = 4,
    parameter int idx_w   = $clog2(num_req)
) (
    input  logic [num_req-1:0] valid_i,
    input  logic [idx_w-1:0]   start_i,
    output logic               found_o,
    output logic [idx_w-1:0]   sel_o
);

    int unsigned idx;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        found_o = 1'b0;
        sel_o   = '0;
        idx     = 0;
        for (int k = 0; k < num_req; k++) begin
            idx = idx_wrap(int'(start_i) + k, num_req);
            if (!found_o && valid_i[idx]) begin
                found_o = 1'b1;
                sel_o   = idx_w'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_enq_arbiter.sv
// Round-robin arbiter sharing one fifo enqueue port, with bounded bursts and flush sequencing.
module fifo_enq_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int num_req   = 4,
    parameter int data_size = 10,
    parameter int max_burst = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [num_req*data_size-1:0]   req_data,
    input  logic [num_req-1:0]             req_valid,
    output logic [num_req-1:0]             req_ready,
    output logic [data_size-1:0]           enq_data,
    output logic [$clog2(num_req)-1:0]     enq_src,
    output logic                           enq_valid,
    input  logic                           enq_ready,
    input  logic                           flush_in,
    output logic                           flush_out,
    output logic                           busy
);

    localparam int IDX_W = $clog2(num_req);
    localparam int CNT_W = $clog2(max_burst + 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             in_grant;
    logic             fire;
    logic             last_beat;
    logic             release_grant;
    logic [IDX_W-1:0] grant_nxt;
    logic [IDX_W-1:0] pick_start;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    assign in_grant  = (state_q == GRANT);
    assign grant_nxt = IDX_W'(idx_wrap(int'(grant_q) + 1, num_req));

    // On release the old owner is searched last, so a lone requester is re-granted at once.
    assign pick_start = (state_q == IDLE) ? ptr_q : grant_nxt;

    rr_pick #(
        .num_req (num_req),
        .idx_w   (IDX_W)
    ) u_pick (
        .valid_i (req_valid),
        .start_i (pick_start),
        .found_o (pick_found),
        .sel_o   (pick_idx)
    );

    assign enq_valid = in_grant && req_valid[grant_q] && !flush_in;
    assign fire      = enq_valid && enq_ready;
    assign enq_src   = grant_q;
    assign enq_data  = in_grant ? req_data[int'(grant_q)*data_size +: data_size] : '0;
    assign flush_out = (state_q == FLUSH);
    assign busy      = (state_q != IDLE);

    assign last_beat     = ((cnt_q + 1'b1) == CNT_W'(max_burst));
    assign release_grant = in_grant && !flush_in &&
                           ((fire && last_beat) || (!fire && !req_valid[grant_q]));

    always_comb begin
        req_ready = '0;
        if (in_grant && enq_ready && !flush_in) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (flush_in) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (pick_found) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (flush_in) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (release_grant) begin
                    ptr_d = grant_nxt;
                    cnt_d = '0;
                    if (pick_found) begin
                        grant_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (fire) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Self-checking bench for fifo_enq_arbiter: vector table, corner-case sequences, random vs reference model.
module tb_fifo_enq_arbiter;

    localparam int N  = 4;
    localparam int DW = 10;
    localparam int MB = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   enq_data;
    logic [1:0]      enq_src;
    logic            enq_valid;
    logic            enq_ready;
    logic            flush_in;
    logic            flush_out;
    logic            busy;

    int total = 0;
    int bad   = 0;

    fifo_enq_arbiter #(
        .num_req   (N),
        .data_size (DW),
        .max_burst (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .enq_data  (enq_data),
        .enq_src   (enq_src),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .flush_in  (flush_in),
        .flush_out (flush_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the port, where the next search starts, beats taken so far.
    int            m_serving, m_flushing, m_owner, m_next, m_taken, m_fire_idx;
    logic          m_fire;
    logic          e_valid, e_flush, e_busy;
    logic [1:0]    e_src;
    logic [N-1:0]  e_ready;
    logic [DW-1:0] e_data;
    logic          rnd_mode = 1'b0;
    logic [DW-1:0] r_data [N];

    typedef struct {
        logic [N-1:0] v;
        logic         rdy;
        logic         ev;
        logic [1:0]   src;
        logic [N-1:0] rd;
        logic         bz;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [1:0] src,
                             input logic [N-1:0] rd, input logic fo, input logic bz);
        check({tag, "_valid"}, 32'(enq_valid), 32'(ev));
        check({tag, "_src"},   32'(enq_src),   32'(src));
        check({tag, "_ready"}, 32'(req_ready), 32'(rd));
        check({tag, "_flush"}, 32'(flush_out), 32'(fo));
        check({tag, "_busy"},  32'(busy),      32'(bz));
    endtask

    function automatic int first_valid(input logic [N-1:0] v, input int s);
        for (int k = 0; k < N; k++) begin
            if (v[(s + k) % N]) return (s + k) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_serving  = 0;
        m_flushing = 0;
        m_owner    = 0;
        m_next     = 0;
        m_taken    = 0;
    endtask

    task automatic model_eval();
        e_valid    = (m_serving != 0) && req_valid[m_owner] && !flush_in;
        e_ready    = ((m_serving != 0) && !flush_in && enq_ready) ? N'(1 << m_owner) : '0;
        e_src      = 2'(m_owner);
        e_flush    = (m_flushing != 0);
        e_busy     = (m_serving != 0) || (m_flushing != 0);
        e_data     = (m_serving != 0) ? req_data[m_owner*DW +: DW] : '0;
        m_fire     = e_valid && enq_ready;
        m_fire_idx = m_owner;
    endtask

    task automatic model_update();
        logic rel;
        rel = 1'b0;
        if (m_flushing != 0) begin
            m_flushing = 0;
        end else if (flush_in) begin
            m_flushing = 1;
            m_serving  = 0;
            m_taken    = 0;
        end else if (m_serving == 0) begin
            if (req_valid != 0) begin
                m_owner   = first_valid(req_valid, m_next);
                m_taken   = 0;
                m_serving = 1;
            end
        end else begin
            if (m_fire) begin
                m_taken++;
                rel = (m_taken == MB);
            end else if (!req_valid[m_owner]) begin
                rel = 1'b1;
            end
            if (rel) begin
                m_next  = (m_owner + 1) % N;
                m_taken = 0;
                if (req_valid != 0) m_owner = first_valid(req_valid, (m_owner + 1) % N);
                else m_serving = 0;
            end
        end
    endtask

    task automatic producer_update();
        for (int i = 0; i < N; i++) begin
            if (m_fire && m_fire_idx == i) begin
                r_data[i] = DW'($urandom);
                if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
            end else if (!req_valid[i] && $urandom_range(0, 9) < 4) begin
                req_valid[i] = 1'b1;
                r_data[i]    = DW'($urandom);
            end
            req_data[i*DW +: DW] = r_data[i];
        end
        enq_ready = ($urandom_range(0, 9) < 7);
        flush_in  = ($urandom_range(0, 29) == 0);
    endtask

    task automatic apply(input logic [N-1:0] v, input logic rdy, input logic fl);
        req_valid = v;
        enq_ready = rdy;
        flush_in  = fl;
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) model_update();
        #1;
        if (rnd_mode) producer_update();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        flush_in  = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_const_data();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(10'h3A0 + i);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        enq_ready = 1'b0;
        flush_in  = 1'b0;
        model_reset();
        #1;
        check_out("reset", 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        check("reset_data", 32'(enq_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fairness with all requesters valid, then backpressure on requester 1.
        tbl[0]  = '{4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
        tbl[1]  = '{4'hF, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1};
        tbl[2]  = '{4'hF, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1};
        tbl[3]  = '{4'hF, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1};
        tbl[4]  = '{4'hF, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1};
        tbl[5]  = '{4'hF, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};
        tbl[6]  = '{4'hF, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};
        tbl[7]  = '{4'hF, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1};
        tbl[8]  = '{4'hF, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1};
        tbl[9]  = '{4'hF, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1};
        tbl[10] = '{4'hF, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1};
        tbl[11] = '{4'hF, 1'b0, 1'b1, 2'd1, 4'h0, 1'b1};
        tbl[12] = '{4'hF, 1'b0, 1'b1, 2'd1, 4'h0, 1'b1};
        tbl[13] = '{4'hF, 1'b0, 1'b1, 2'd1, 4'h0, 1'b1};
        tbl[14] = '{4'hF, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1};
        tbl[15] = '{4'hF, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1};
        tbl[16] = '{4'hF, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};

        set_const_data();
        for (int k = 0; k < 17; k++) begin
            apply(tbl[k].v, tbl[k].rdy, 1'b0);
            check_out($sformatf("tbl%0d", k), tbl[k].ev, tbl[k].src, tbl[k].rd, 1'b0, tbl[k].bz);
            if (tbl[k].ev) check($sformatf("tbl%0d_data", k), 32'(enq_data), 32'(10'h3A0 + tbl[k].src));
            advance();
        end

        // Single requester streaming 1,2,3 with a re-grant after beat 2.
        do_reset();
        req_data = '0;
        req_data[DW-1:0] = 10'd1;
        apply(4'h1, 1'b1, 1'b0);
        check_out("single_req", 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        advance();
        for (int b = 1; b <= 3; b++) begin
            req_data[DW-1:0] = DW'(b);
            apply(4'h1, 1'b1, 1'b0);
            check_out($sformatf("single_b%0d", b), 1'b1, 2'd0, 4'h1, 1'b0, 1'b1);
            check($sformatf("single_d%0d", b), 32'(enq_data), 32'(b));
            advance();
        end
        apply(4'h0, 1'b1, 1'b0);
        check_out("single_drop", 1'b0, 2'd0, 4'h1, 1'b0, 1'b1);
        advance();
        apply(4'h0, 1'b1, 1'b0);
        check_out("single_idle", 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        advance();

        // Early drop by requester 2, then flush with a repeated flush_in, resume from ptr=3.
        do_reset();
        set_const_data();
        apply(4'h4, 1'b1, 1'b0);
        check_out("drop_req", 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        advance();
        apply(4'h4, 1'b1, 1'b0);
        check_out("drop_beat", 1'b1, 2'd2, 4'h4, 1'b0, 1'b1);
        check("drop_beat_data", 32'(enq_data), 32'(10'h3A2));
        advance();
        apply(4'h1, 1'b1, 1'b0);
        check_out("drop_gone", 1'b0, 2'd2, 4'h4, 1'b0, 1'b1);
        advance();
        apply(4'hB, 1'b1, 1'b1);
        check_out("flush_t0", 1'b0, 2'd0, 4'h0, 1'b0, 1'b1);
        advance();
        apply(4'hB, 1'b1, 1'b1);
        check_out("flush_t1", 1'b0, 2'd0, 4'h0, 1'b1, 1'b1);
        advance();
        apply(4'hB, 1'b1, 1'b0);
        check_out("flush_t2", 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        advance();
        apply(4'hB, 1'b1, 1'b0);
        check_out("flush_t3", 1'b1, 2'd3, 4'h8, 1'b0, 1'b1);
        advance();

        // Asynchronous reset in the middle of requester 3's burst.
        rst_n = 1'b0;
        model_reset();
        #1;
        check_out("rst_mid", 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        check("rst_mid_data", 32'(enq_data), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply(4'hF, 1'b1, 1'b0);
        check_out("rst_idle", 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        advance();
        apply(4'hF, 1'b1, 1'b0);
        check_out("rst_regrant", 1'b1, 2'd0, 4'h1, 1'b0, 1'b1);
        advance();

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < N; i++) r_data[i] = '0;
        req_data  = '0;
        enq_ready = 1'b1;
        rnd_mode  = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            apply(req_valid, enq_ready, flush_in);
            check_out("rnd", e_valid, e_src, e_ready, e_flush, e_busy);
            check("rnd_data", 32'(enq_data), 32'(e_data));
            advance();
        end
        rnd_mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
